dmem_ctrl: RTL

Parametrised, multi-cycle data-memory controller for the MIPS core's data side. It generalises the single-cycle, word-only data memory to a configurable size, adds byte-lane write enables, programmable wait states with a req/ready handshake, out-of-range error reporting, and a combinational debug read port. It sits between the core's load/store path and the on-chip data array. The core stalls on `busy` until `ready` pulses.

---
 rtl/dmem_ctrl_if.sv | 23 ++
 rtl/dmem_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the core's load/store path and dmem_ctrl.
// The core is the master; the controller is the slave.
interface dmem_ctrl_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] q;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, be, a, d,
        input  q, ready, err, busy
    );

    modport slave (
        input  req, we, be, a, d,
        output q, ready, err, busy
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: byte-lane writes, programmable wait
// states, out-of-range error reporting and a combinational debug read port.
module dmem_ctrl #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_ctrl_if.slave        bus,
    input  logic [ADDR_W-1:0] dbg_a,
    output logic [31:0]       dbg_q
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] a_q, a_d;
    logic [31:0] d_q, d_d;
    logic [31:0] q_q, q_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic [31:0]       mem_q [DEPTH];
    logic              commit;
    logic              oor;
    logic              mem_we;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rd_word;
    logic [31:0]       wr_word;

    assign commit  = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign oor     = (a_q >> (ADDR_W + 2)) != 32'd0;
    assign idx     = a_q[ADDR_W+1:2];
    assign rd_word = mem_q[idx];
    assign mem_we  = commit && we_q && !oor;

    // Disabled lanes write back the word's current byte.
    always_comb begin
        wr_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) wr_word[8*i +: 8] = d_q[8*i +: 8];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.req) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == 4'd0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every signal gets a hold default up front so no path through
    // the case leaves it unassigned and infers a latch.
    always_comb begin
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        a_d     = a_q;
        d_d     = d_q;
        q_d     = q_q;
        err_d   = err_q;
        ready_d = 1'b0;
        busy_d  = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    we_d  = bus.we;
                    be_d  = bus.be;
                    a_d   = bus.a;
                    d_d   = bus.d;
                    cnt_d = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    err_d   = oor;
                    q_d     = oor ? 32'd0 : rd_word;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            a_q     <= 32'd0;
            d_q     <= 32'd0;
            q_q     <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            a_q     <= a_d;
            d_q     <= d_d;
            q_q     <= q_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: the array has no reset; its contents must survive a core reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= wr_word;
    end

    assign bus.q     = q_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
    assign dbg_q     = mem_q[dbg_a];
endmodule
